conv_stream_feeder: RTL and testbench
=====================================

CONV_STREAM_FEEDER -- requirements
Module: conv_stream_feeder

Interface
REQ-001 Parameter FEATURE_MAP_WIDTH, default 1024: columns per feature-map row, and the number of compute bursts per row.
REQ-002 Parameter FEATURE_MAP_HEIGHT, default 1024: rows per output channel.
REQ-003 Parameter OUTPUT_NB_CHANNELS, default 64: output-channel passes per run.
REQ-004 Parameter DATA_WIDTH, default 16: width of memory and stream words.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port arst_in, input, 1: reset, asynchronous and active-high.
REQ-007 Port start, input, 1: begin a run; sampled only in IDLE.
REQ-008 Port running, output, 1: high in every state except IDLE.
REQ-009 Port done, output, 1: one-cycle pulse after the final beat of a run.
REQ-010 Ports cfg_kernel_base and cfg_input_base, input, 32 each: word base addresses, latched when start is accepted.
REQ-011 Port mem_re, output, 1: memory read enable.
REQ-012 Port mem_addr, output, 32: memory read address.
REQ-013 Port mem_rdata, input, DATA_WIDTH: read data, valid exactly 1 cycle after mem_re.
REQ-014 Port con_valid, output, 1: stream word valid.
REQ-015 Port con_ready, input, 1: device ready.
REQ-016 Port con_data, output, DATA_WIDTH: stream word.
REQ-017 Port proto_err, output, 1: sticky protocol-violation flag.

Function
REQ-018 Burst order SHALL be as follows:
- For each channel c in 0..OUTPUT_NB_CHANNELS-1: 6 kernel bursts of 12 words.
- Then, for each row y: 3 input bursts of 4 words.
- Then, for each column x: 1 compute burst of 4 words.
REQ-019 States SHALL be IDLE, FETCH, OFFER, STREAM and DONE, with these transitions:
- IDLE->FETCH when start=1.
- FETCH->OFFER after the burst buffer is full.
- OFFER->STREAM on con_valid&&con_ready.
- STREAM->FETCH after the last beat, if bursts remain.
- STREAM->DONE after the last beat of the run.
- DONE->IDLE unconditionally.
REQ-020 FETCH SHALL assert mem_re on L consecutive cycles (L = burst length) with mem_addr incrementing by 1 per read, then spend one drain cycle capturing the final mem_rdata.
- If start is accepted at edge k, reads occur in cycles k+1..k+L and OFFER begins in cycle k+L+2.
REQ-021 In OFFER, con_valid=1 and con_data=buf[0]; both SHALL be held stable until con_ready=1.
REQ-022 STREAM SHALL present beats 1..L-1 on consecutive cycles (con_valid=1, con_data=buf[i]) without waiting on con_ready, because the device consumes every cycle after the first beat.
REQ-023 con_valid SHALL be 0 outside OFFER and STREAM; mem_re SHALL be 0 outside FETCH.
REQ-024 The kernel address pointer SHALL continue linearly across channels; the input address pointer SHALL reload cfg_input_base at the start of each channel.
REQ-025 Beat, burst, row, column and channel counters SHALL wrap to 0 on their last value, nested in the REQ-018 order.
REQ-026 start SHALL be ignored while running=1.
REQ-027 done SHALL be high only in DONE.

Reset
REQ-028 While arst_in=1, the following SHALL hold immediately, without waiting for a clock edge:
- state=IDLE and all counters=0.
- running, done, mem_re, con_valid and proto_err=0.
- mem_addr and con_data=0.
REQ-029 Reset mid-run SHALL abandon the run; the next accepted start SHALL restart from the newly latched base addresses.

Configuration
REQ-030 Macro FEEDER_PROTOCOL_CHECK_EN, when defined: proto_err SHALL set when con_ready=0 during any STREAM beat, and SHALL stay high until reset.
REQ-031 Without FEEDER_PROTOCOL_CHECK_EN, proto_err SHALL be tied to 0, with no checking logic.

Verification
REQ-032 W=2, H=1, CH=1, con_ready=1 throughout -> 11 bursts and 92 beats total (72 kernel + 12 input + 8 compute), then one done pulse and running=0.
REQ-033 con_ready held low for 5 cycles in the first OFFER -> con_valid=1 and con_data stable for all 5 cycles; beat 1 appears the cycle after the handshake.
REQ-034 cfg_kernel_base=0x100, cfg_input_base=0x1000, CH=2 -> channel-1 kernel reads start at 0x148; channel-1 input reads restart at 0x1000.
REQ-035 con_ready dropped at beat 3 of a kernel burst -> proto_err=1 and remains 1 until reset (macro defined); proto_err=0 (macro undefined).
REQ-036 arst_in pulsed mid-STREAM -> con_valid, mem_re and running=0 during the reset; a following start reads from cfg_kernel_base.
REQ-037 start pulsed during FETCH -> no effect; burst sequence and addresses are unchanged.

Source files
------------

// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: fetches kernel, input-row and compute bursts from a
// word-addressed memory into a small buffer and replays each burst onto a
// valid/ready stream. The first beat of a burst waits for con_ready; the
// remaining beats go out back to back.
// Optional build macro: FEEDER_PROTOCOL_CHECK_EN (sticky proto_err when the
// device deasserts con_ready during a streamed beat).
module conv_stream_feeder #(
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  parameter int unsigned DATA_WIDTH         = 16
) (
  input  logic                  clk,
  input  logic                  arst_in,
  input  logic                  start,
  output logic                  running,
  output logic                  done,
  input  logic [31:0]           cfg_kernel_base,
  input  logic [31:0]           cfg_input_base,
  output logic                  mem_re,
  output logic [31:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  con_valid,
  input  logic                  con_ready,
  output logic [DATA_WIDTH-1:0] con_data,
  output logic                  proto_err
);

  localparam int unsigned XW = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
  localparam int unsigned YW = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int unsigned CW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(FEATURE_MAP_WIDTH  - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(OUTPUT_NB_CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_OFFER,
    S_STREAM,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_KERNEL,
    PH_INPUT,
    PH_COMPUTE
  } phase_e;

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic [3:0]      beat_q, beat_d;
  logic [2:0]      kb_q, kb_d;
  logic [1:0]      ib_q, ib_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   c_q, c_d;
  logic [31:0]     kptr_q, kptr_d;
  logic [31:0]     iptr_q, iptr_d;
  logic [31:0]     ibase_q, ibase_d;

  logic [DATA_WIDTH-1:0] buf_q [0:11];

  logic [3:0] burst_len;
  logic       run_end;

  assign burst_len = (phase_q == PH_KERNEL) ? 4'd12 : 4'd4;

  // State, counters and address pointers
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q <= S_IDLE;
      phase_q <= PH_KERNEL;
      fcnt_q  <= '0;
      beat_q  <= '0;
      kb_q    <= '0;
      ib_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      kptr_q  <= '0;
      iptr_q  <= '0;
      ibase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      fcnt_q  <= fcnt_d;
      beat_q  <= beat_d;
      kb_q    <= kb_d;
      ib_q    <= ib_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      kptr_q  <= kptr_d;
      iptr_q  <= iptr_d;
      ibase_q <= ibase_d;
    end
  end

  // Burst buffer: read i returns data one cycle later, so slot fcnt-1 is
  // written on every FETCH cycle after the first (the last one is the drain)
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH && fcnt_q != 4'd0) begin
      buf_q[fcnt_q - 4'd1] <= mem_rdata;
    end
  end

  // Next-state, burst sequencing and output decode
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    fcnt_d    = fcnt_q;
    beat_d    = beat_q;
    kb_d      = kb_q;
    ib_d      = ib_q;
    x_d       = x_q;
    y_d       = y_q;
    c_d       = c_q;
    kptr_d    = kptr_q;
    iptr_d    = iptr_q;
    ibase_d   = ibase_q;
    run_end   = 1'b0;
    running   = (state_q != S_IDLE);
    done      = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    con_valid = 1'b0;
    con_data  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ibase_d = cfg_input_base;
          kptr_d  = cfg_kernel_base;
          iptr_d  = cfg_input_base;
          phase_d = PH_KERNEL;
          fcnt_d  = '0;
          beat_d  = '0;
          kb_d    = '0;
          ib_d    = '0;
          x_d     = '0;
          y_d     = '0;
          c_d     = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (fcnt_q == burst_len) begin
          fcnt_d  = '0;
          state_d = S_OFFER;
        end else begin
          mem_re = 1'b1;
          if (phase_q == PH_KERNEL) begin
            mem_addr = kptr_q;
            kptr_d   = kptr_q + 32'd1;
          end else begin
            mem_addr = iptr_q;
            iptr_d   = iptr_q + 32'd1;
          end
          fcnt_d = fcnt_q + 4'd1;
        end
      end

      S_OFFER: begin
        con_valid = 1'b1;
        con_data  = buf_q[0];
        if (con_ready) begin
          beat_d  = 4'd1;
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        con_valid = 1'b1;
        con_data  = buf_q[beat_q];
        if (beat_q == burst_len - 4'd1) begin
          beat_d = '0;
          // Counters nest kernel -> input -> column -> row -> channel; the
          // input pointer restarts from the latched base at each new channel
          case (phase_q)
            PH_KERNEL: begin
              if (kb_q == 3'd5) begin
                kb_d    = '0;
                phase_d = PH_INPUT;
              end else begin
                kb_d = kb_q + 3'd1;
              end
            end
            PH_INPUT: begin
              if (ib_q == 2'd2) begin
                ib_d    = '0;
                phase_d = PH_COMPUTE;
              end else begin
                ib_d = ib_q + 2'd1;
              end
            end
            default: begin
              if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                  y_d = '0;
                  if (c_q == C_LAST) begin
                    c_d     = '0;
                    run_end = 1'b1;
                  end else begin
                    c_d     = c_q + 1'b1;
                    phase_d = PH_KERNEL;
                    iptr_d  = ibase_q;
                  end
                end else begin
                  y_d     = y_q + 1'b1;
                  phase_d = PH_INPUT;
                end
              end else begin
                x_d = x_q + 1'b1;
              end
            end
          endcase
          state_d = run_end ? S_DONE : S_FETCH;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef FEEDER_PROTOCOL_CHECK_EN
  logic perr_q;

  // Sticky flag: the device must accept every streamed beat
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      perr_q <= 1'b0;
    end else if (state_q == S_STREAM && !con_ready) begin
      perr_q <= 1'b1;
    end
  end

  assign proto_err = perr_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Self-checking bench for conv_stream_feeder (W=2, H=1, CH=2).
// A behavioural memory returns a hash of the address; expected read addresses
// and stream words are queued per run and popped as the DUT produces them.
module tb_conv_stream_feeder;

  localparam int unsigned W  = 2;
  localparam int unsigned H  = 1;
  localparam int unsigned CH = 2;
  localparam int unsigned DW = 16;

`ifdef FEEDER_PROTOCOL_CHECK_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_in;
  logic          start;
  logic          running;
  logic          done;
  logic [31:0]   cfg_kernel_base;
  logic [31:0]   cfg_input_base;
  logic          mem_re;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          con_valid;
  logic          con_ready;
  logic [DW-1:0] con_data;
  logic          proto_err;

  always #5 clk = ~clk;

  conv_stream_feeder #(
    .FEATURE_MAP_WIDTH (W),
    .FEATURE_MAP_HEIGHT(H),
    .OUTPUT_NB_CHANNELS(CH),
    .DATA_WIDTH        (DW)
  ) dut (
    .clk            (clk),
    .arst_in        (arst_in),
    .start          (start),
    .running        (running),
    .done           (done),
    .cfg_kernel_base(cfg_kernel_base),
    .cfg_input_base (cfg_input_base),
    .mem_re         (mem_re),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .con_valid      (con_valid),
    .con_ready      (con_ready),
    .con_data       (con_data),
    .proto_err      (proto_err)
  );

  function automatic logic [15:0] memf(input logic [31:0] a);
    return {a[11:0], a[15:12]} ^ 16'h5A3C ^ {8'h00, a[23:16]};
  endfunction

  // Memory: data valid one cycle after the read
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= memf(mem_addr);
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0]  q_addr[$];
  logic [15:0]  q_data[$];
  int unsigned  q_len[$];
  logic [31:0]  burst_starts[$];

  task automatic push_burst(input int unsigned len, inout logic [31:0] p);
    q_len.push_back(len);
    for (int unsigned i = 0; i < len; i++) begin
      q_addr.push_back(p);
      q_data.push_back(memf(p));
      p = p + 32'd1;
    end
  endtask

  task automatic push_run(input logic [31:0] kb, input logic [31:0] ib);
    logic [31:0] kp;
    logic [31:0] ip;
    kp = kb;
    for (int unsigned c = 0; c < CH; c++) begin
      ip = ib;
      for (int unsigned b = 0; b < 6; b++) push_burst(12, kp);
      for (int unsigned y = 0; y < H; y++) begin
        for (int unsigned b = 0; b < 3; b++) push_burst(4, ip);
        for (int unsigned x = 0; x < W; x++) push_burst(4, ip);
      end
    end
  endtask

  bit          mon_en      = 1'b0;
  int unsigned beat_idx    = 0;
  int unsigned cur_len     = 0;
  int unsigned beats_total = 0;
  int unsigned bursts_total = 0;
  int unsigned done_cnt    = 0;
  logic        prev_re     = 1'b0;

  // Monitor: reads against expected addresses, accepted beats against data
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_re) begin
        if (!prev_re) burst_starts.push_back(mem_addr);
        chk("read_expected", 32'(q_addr.size() != 0), 32'd1);
        if (q_addr.size() != 0) chk("mem_addr", mem_addr, q_addr.pop_front());
      end
      prev_re = mem_re;
      if (con_valid && (beat_idx != 0 || con_ready)) begin
        chk("beat_expected", 32'(q_data.size() != 0), 32'd1);
        if (q_data.size() != 0) chk("con_data", 32'(con_data), 32'(q_data.pop_front()));
        if (beat_idx == 0) begin
          bursts_total++;
          cur_len = (q_len.size() != 0) ? q_len.pop_front() : 4;
        end
        beat_idx++;
        beats_total++;
        if (beat_idx == cur_len) beat_idx = 0;
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    beats_total  = 0;
    bursts_total = 0;
    done_cnt     = 0;
    beat_idx     = 0;
    burst_starts.delete();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_running_in_done"}, 32'(running), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, "_running_after"}, 32'(running), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt, 32'd1);
    chk({tag, "_beats"}, beats_total, 32'd184);
    chk({tag, "_bursts"}, bursts_total, 32'd22);
    chk({tag, "_q_empty"}, 32'(q_addr.size() + q_data.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] d0;
    int n;

    arst_in         = 1'b1;
    start           = 1'b0;
    con_ready       = 1'b0;
    cfg_kernel_base = '0;
    cfg_input_base  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_running",   32'(running),   32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_mem_re",    32'(mem_re),    32'd0);
    chk("rst_con_valid", 32'(con_valid), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_con_data",  32'(con_data),  32'd0);
    arst_in = 1'b0;
    tick();

    // Run A: latency, held offer, channel-1 address restart
    cfg_kernel_base = 32'h100;
    cfg_input_base  = 32'h1000;
    push_run(32'h100, 32'h1000);
    mon_en = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    @(negedge clk);
    chk("first_read_re",   32'(mem_re), 32'd1);
    chk("first_read_addr", mem_addr,    32'h100);
    n = 1;
    while (!con_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("offer_latency", n, 32'd14);
    d0 = con_data;
    chk("offer_data", 32'(d0), 32'(memf(32'h100)));
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk("offer_hold_valid", 32'(con_valid), 32'd1);
      chk("offer_hold_data",  32'(con_data),  32'(d0));
    end
    tick();
    con_ready = 1'b1;
    @(negedge clk);
    chk("handshake_valid", 32'(con_valid), 32'd1);
    @(negedge clk);
    chk("beat1_valid", 32'(con_valid), 32'd1);
    chk("beat1_data",  32'(con_data),  32'(memf(32'h101)));
    wait_done("runA");
    chk("runA_nbursts",   32'(burst_starts.size()), 32'd22);
    chk("ch0_input_base", burst_starts[6],  32'h1000);
    chk("ch1_kernel_base", burst_starts[11], 32'h148);
    chk("ch1_input_base", burst_starts[17], 32'h1000);

    // Run B: ready dropped at beat 3, then reset mid-stream
    clear_stats();
    cfg_kernel_base = 32'h400;
    cfg_input_base  = 32'h800;
    push_run(32'h400, 32'h800);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!con_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("runB_offer", 32'(con_valid), 32'd1);
    tick();
    tick();
    tick();
    con_ready = 1'b0;
    tick();
    con_ready = 1'b1;
    @(negedge clk);
    chk("proto_err_set", 32'(proto_err), 32'(EXP_PERR));
    repeat (20) @(negedge clk);
    chk("proto_err_sticky", 32'(proto_err), 32'(EXP_PERR));
    n = 0;
    while (beats_total < 30 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_streaming", 32'(con_valid), 32'd1);
    #2;
    mon_en  = 1'b0;
    arst_in = 1'b1;
    #1;
    chk("midrst_con_valid", 32'(con_valid), 32'd0);
    chk("midrst_mem_re",    32'(mem_re),    32'd0);
    chk("midrst_running",   32'(running),   32'd0);
    chk("midrst_proto_err", 32'(proto_err), 32'd0);
    chk("midrst_con_data",  32'(con_data),  32'd0);
    q_addr.delete();
    q_data.delete();
    q_len.delete();
    prev_re = 1'b0;
    clear_stats();
    tick();
    arst_in = 1'b0;
    tick();

    // Run C: fresh bases after reset; start pulsed during FETCH is ignored
    cfg_kernel_base = 32'h2000;
    cfg_input_base  = 32'h3000;
    push_run(32'h2000, 32'h3000);
    mon_en = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (3) tick();
    chk("runC_in_fetch", 32'(mem_re), 32'd1);
    cfg_kernel_base = 32'h7000;
    cfg_input_base  = 32'h7800;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("runC");
    chk("runC_kernel_base", burst_starts[0],  32'h2000);
    chk("runC_ch1_input",   burst_starts[17], 32'h3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
